uart_rx_frame_ctrl: RTL

//  UART receive frame controller. Sits directly upstream of the RX parity checker.

---
 rtl/uart_rx_frame_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: 3-point majority oversampling, START/DATA/PARITY/STOP
// sequencing, LSB-first deserialisation and a parity-checker handshake.
module uart_rx_frame_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int PRSC_WIDTH = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [PRSC_WIDTH-1:0] Prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYPE,
   input  logic                  par_err,
   output logic                  sampled_bit,
   output logic                  par_chk_en,
   output logic                  par_chk_type,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  framing_err
);

   localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BCW-1:0]        LAST_BIT = BCW'(DATA_WIDTH - 1);
   localparam logic [BCW-1:0]        BIT_ONE  = BCW'(1);
   localparam logic [PRSC_WIDTH-1:0] P_MIN    = PRSC_WIDTH'(8);
   localparam logic [PRSC_WIDTH-1:0] ONE      = PRSC_WIDTH'(1);
   localparam logic [PRSC_WIDTH-1:0] TWO      = PRSC_WIDTH'(2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                  state_q, state_d;
   logic [PRSC_WIDTH-1:0]   edge_cnt_q, edge_cnt_d;
   logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
   logic [PRSC_WIDTH-1:0]   prsc_q, prsc_d;
   logic                    par_en_q, par_en_d;
   logic                    par_type_q, par_type_d;
   logic [2:0]              samp_q, samp_d;
   logic                    sampled_bit_q, sampled_bit_d;
   logic [DATA_WIDTH-1:0]   shift_q, shift_d;
   logic                    par_chk_en_q, par_chk_en_d;
   logic                    par_err_q, par_err_d;
   logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
   logic                    data_valid_q, data_valid_d;
   logic                    framing_err_q, framing_err_d;

   logic [PRSC_WIDTH-1:0]   half;
   logic                    at_hm1, at_h, at_hp1, at_dec, at_last;
   logic                    maj;
   logic                    load_bit;

   // Bit timing is derived from the prescale latched at start detect, never the live input.
   assign half    = prsc_q >> 1;
   assign at_hm1  = (edge_cnt_q == half - ONE);
   assign at_h    = (edge_cnt_q == half);
   assign at_hp1  = (edge_cnt_q == half + ONE);
   assign at_dec  = (edge_cnt_q == half + TWO);
   assign at_last = (edge_cnt_q == prsc_q - ONE);

   assign maj      = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
   assign load_bit = (state_q == S_DATA) && at_dec;

   // State register and datapath registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= S_IDLE;
         edge_cnt_q    <= '0;
         bit_cnt_q     <= '0;
         prsc_q        <= P_MIN;
         par_en_q      <= 1'b0;
         par_type_q    <= 1'b0;
         samp_q        <= '0;
         sampled_bit_q <= 1'b0;
         shift_q       <= '0;
         par_chk_en_q  <= 1'b0;
         par_err_q     <= 1'b0;
         p_data_q      <= '0;
         data_valid_q  <= 1'b0;
         framing_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         edge_cnt_q    <= edge_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         prsc_q        <= prsc_d;
         par_en_q      <= par_en_d;
         par_type_q    <= par_type_d;
         samp_q        <= samp_d;
         sampled_bit_q <= sampled_bit_d;
         shift_q       <= shift_d;
         par_chk_en_q  <= par_chk_en_d;
         par_err_q     <= par_err_d;
         p_data_q      <= p_data_d;
         data_valid_q  <= data_valid_d;
         framing_err_q <= framing_err_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (!RX_IN) state_d = S_START;
         end
         S_START: begin
            if (at_dec && maj)  state_d = S_IDLE;
            else if (at_last)   state_d = S_DATA;
         end
         S_DATA: begin
            if (at_last && (bit_cnt_q == LAST_BIT))
               state_d = par_en_q ? S_PARITY : S_STOP;
         end
         S_PARITY: begin
            if (at_last) state_d = S_STOP;
         end
         S_STOP: begin
            if (at_last) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath and registered-output next values
   always_comb begin
      edge_cnt_d    = edge_cnt_q;
      bit_cnt_d     = bit_cnt_q;
      prsc_d        = prsc_q;
      par_en_d      = par_en_q;
      par_type_d    = par_type_q;
      samp_d        = samp_q;
      sampled_bit_d = sampled_bit_q;
      par_chk_en_d  = 1'b0;
      par_err_d     = par_err_q;
      p_data_d      = p_data_q;
      data_valid_d  = 1'b0;
      framing_err_d = 1'b0;

      if (state_q == S_IDLE) begin
         edge_cnt_d = '0;
         bit_cnt_d  = '0;
         if (!RX_IN) begin
            // The detect cycle itself is edge 0 of the start bit.
            edge_cnt_d = ONE;
            prsc_d     = (Prescale < P_MIN) ? P_MIN : Prescale;
            par_en_d   = PAR_EN;
            par_type_d = PAR_TYPE;
            par_err_d  = 1'b0;
         end
      end else begin
         edge_cnt_d = at_last ? '0 : edge_cnt_q + ONE;

         if (at_hm1) samp_d[0] = RX_IN;
         if (at_h)   samp_d[1] = RX_IN;
         if (at_hp1) samp_d[2] = RX_IN;
         if (at_dec) sampled_bit_d = maj;

         if ((state_q == S_START) && at_dec && maj)
            edge_cnt_d = '0;

         if ((state_q == S_DATA) && at_last)
            bit_cnt_d = bit_cnt_q + BIT_ONE;

         if ((state_q == S_PARITY) && at_dec)
            par_chk_en_d = 1'b1;

         // The checker answers during the cycle the strobe is high.
         if (par_chk_en_q)
            par_err_d = par_err;

         if ((state_q == S_STOP) && at_last) begin
            data_valid_d  = sampled_bit_q & ~par_err_q;
            framing_err_d = ~sampled_bit_q;
            if (sampled_bit_q && !par_err_q)
               p_data_d = shift_q;
         end
      end
   end

   // Per-bit load of the deserialiser, addressed by bit_cnt.
   generate
      for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_shift
         assign shift_d[gi] = (load_bit && (bit_cnt_q == BCW'(gi))) ? maj : shift_q[gi];
      end
   endgenerate

   assign sampled_bit  = sampled_bit_q;
   assign par_chk_en   = par_chk_en_q;
   assign par_chk_type = par_type_q;
   assign P_DATA       = p_data_q;
   assign data_valid   = data_valid_q;
   assign framing_err  = framing_err_q;

endmodule
